// File: rtl/proc_pkg.sv
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared processor types and constants (word width, register
//                count, well-known register indices).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int LARGURA_PALAVRA = 32;
    localparam int NUM_REGS        = 32;
    localparam int END_W           = $clog2(NUM_REGS);

    typedef logic [LARGURA_PALAVRA-1:0] palavra_t;
    typedef logic [END_W-1:0]           end_reg_t;

    localparam end_reg_t REG_ZERO = end_reg_t'(0);
    localparam end_reg_t REG_RA   = end_reg_t'(31);

endpackage

`default_nettype wire

// File: rtl/banco_de_registradores_porta_leitura.sv
// ============================================================================
//  Module      : porta_leitura
//  Description : Combinational register-file read port with zero-register
//                detect and optional write-through forwarding (BANCO_BYPASS_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module porta_leitura
    import proc_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PALAVRA,
    parameter int NREGS    = 32,
    parameter int ENDW     = $clog2(NREGS)
) (
    input  logic [NREGS-1:0][LARGURA-1:0] regs_i,
    input  logic [ENDW-1:0]               end_i,
`ifdef BANCO_BYPASS_EN
    input  logic                          wr_valido_i,
    input  logic [ENDW-1:0]               wr_end_i,
    input  logic [LARGURA-1:0]            wr_dado_i,
`endif
    output logic [LARGURA-1:0]            dado_o
);

    always_comb begin
        dado_o = regs_i[end_i];
        if (end_i == '0) begin
            dado_o = '0;
        end
`ifdef BANCO_BYPASS_EN
        // wr_valido_i already excludes reset and address 0
        if (wr_valido_i && (wr_end_i == end_i)) begin
            dado_o = wr_dado_i;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/banco_de_registradores.sv
// ============================================================================
//  Module      : banco_de_registradores
//  Description : MIPS32 register file: two combinational read ports, one
//                synchronous write port, one debug read port, r0 hardwired 0.
//                Optional write-through forwarding with macro BANCO_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banco_de_registradores
    import proc_pkg::*;
#(
    parameter int LARGURA  = proc_pkg::LARGURA_PALAVRA,
    parameter int NUM_REGS = proc_pkg::NUM_REGS,
    parameter int END_W    = $clog2(NUM_REGS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [END_W-1:0]   rs,
    input  logic [END_W-1:0]   rt,
    output logic [LARGURA-1:0] out_rs,
    output logic [LARGURA-1:0] out_rt,
    input  logic               escrever,
    input  logic [END_W-1:0]   rd_escrita,
    input  logic [LARGURA-1:0] dado_escrita,
    input  logic [END_W-1:0]   dbg_end,
    output logic [LARGURA-1:0] dbg_dado
);

    logic [NUM_REGS-1:0][LARGURA-1:0] regs_q;
    logic [NUM_REGS-1:0][LARGURA-1:0] regs_d;
    logic                             escrita_ok;

    assign escrita_ok = escrever && (rd_escrita != '0);

    // Storage is only touched when a write is enabled, so X on the write
    // bus cannot leak into the array while escrever is low.
    always_comb begin
        regs_d = regs_q;
        if (escrita_ok) begin
            regs_d[rd_escrita] = dado_escrita;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef BANCO_BYPASS_EN
    logic wr_valido;
    assign wr_valido = escrita_ok && !reset;
`endif

    porta_leitura #(
        .LARGURA (LARGURA),
        .NREGS   (NUM_REGS),
        .ENDW    (END_W)
    ) u_porta_rs (
        .regs_i      (regs_q),
        .end_i       (rs),
`ifdef BANCO_BYPASS_EN
        .wr_valido_i (wr_valido),
        .wr_end_i    (rd_escrita),
        .wr_dado_i   (dado_escrita),
`endif
        .dado_o      (out_rs)
    );

    porta_leitura #(
        .LARGURA (LARGURA),
        .NREGS   (NUM_REGS),
        .ENDW    (END_W)
    ) u_porta_rt (
        .regs_i      (regs_q),
        .end_i       (rt),
`ifdef BANCO_BYPASS_EN
        .wr_valido_i (wr_valido),
        .wr_end_i    (rd_escrita),
        .wr_dado_i   (dado_escrita),
`endif
        .dado_o      (out_rt)
    );

    porta_leitura #(
        .LARGURA (LARGURA),
        .NREGS   (NUM_REGS),
        .ENDW    (END_W)
    ) u_porta_dbg (
        .regs_i      (regs_q),
        .end_i       (dbg_end),
`ifdef BANCO_BYPASS_EN
        .wr_valido_i (wr_valido),
        .wr_end_i    (rd_escrita),
        .wr_dado_i   (dado_escrita),
`endif
        .dado_o      (dbg_dado)
    );

endmodule

`default_nettype wire

// File: tb/tb_banco_de_registradores.sv
// ============================================================================
//  Module      : tb_banco_de_registradores
//  Description : Self-checking bench for banco_de_registradores (directed
//                vector table plus reset sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banco_de_registradores;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt, rd_escrita, dbg_end;
    logic        escrever;
    logic [31:0] dado_escrita;
    logic [31:0] out_rs, out_rt, dbg_dado;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    banco_de_registradores dut (
        .clock        (clock),
        .reset        (reset),
        .rs           (rs),
        .rt           (rt),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .escrever     (escrever),
        .rd_escrita   (rd_escrita),
        .dado_escrita (dado_escrita),
        .dbg_end      (dbg_end),
        .dbg_dado     (dbg_dado)
    );

    typedef struct {
        logic        esc;
        logic [4:0]  rd;
        logic [31:0] dado;
        logic [4:0]  a_rs;
        logic [4:0]  a_rt;
        logic [4:0]  a_dbg;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_dbg;
    } vetor_t;

    localparam int NV = 9;
    vetor_t tab [NV];

`ifdef BANCO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nome, atual, esperado);
        end
    endtask

    task automatic dirige(input logic e, input logic [4:0] d, input logic [31:0] v,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        escrever = e; rd_escrita = d; dado_escrita = v;
        rs = a; rt = b; dbg_end = c;
    endtask

    initial begin
        // Inputs are set on the falling edge and checked 1 time unit later,
        // so every check sees the state before the following rising edge.
        tab[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,
                   BYP ? 32'hDEADBEEF : 32'h0, 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
        tab[1] = '{1'b1, 5'd31, 32'h00000001, 5'd5,  5'd31, 5'd31,
                   32'hDEADBEEF, BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0};
        tab[2] = '{1'b0, 5'd7,  32'h12345678, 5'd5,  5'd31, 5'd5,
                   32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF};
        tab[3] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,
                   32'h0, 32'h0, 32'h0};
        tab[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,
                   32'h0, 32'h0, 32'h0};
        tab[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd0,
                   32'h0, 32'hDEADBEEF, 32'h0};
        tab[6] = '{1'b1, 5'd9,  32'hAAAA0000, 5'd1,  5'd2,  5'd31,
                   32'h0, 32'h0, 32'h00000001};
        tab[7] = '{1'b1, 5'd9,  32'h5555FFFF, 5'd9,  5'd9,  5'd31,
                   BYP ? 32'h5555FFFF : 32'hAAAA0000,
                   BYP ? 32'h5555FFFF : 32'hAAAA0000, 32'h00000001};
        tab[8] = '{1'b0, 5'd9,  32'h0,        5'd9,  5'd5,  5'd9,
                   32'h5555FFFF, 32'hDEADBEEF, 32'h5555FFFF};

        reset = 1'b1;
        dirige(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(i); dbg_end = 5'(i);
            #1;
            chk($sformatf("reset_rs[%0d]", i),  out_rs,   32'h0);
            chk($sformatf("reset_rt[%0d]", i),  out_rt,   32'h0);
            chk($sformatf("reset_dbg[%0d]", i), dbg_dado, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            dirige(tab[i].esc, tab[i].rd, tab[i].dado, tab[i].a_rs, tab[i].a_rt, tab[i].a_dbg);
            #1;
            chk($sformatf("vec%0d_out_rs", i),   out_rs,   tab[i].e_rs);
            chk($sformatf("vec%0d_out_rt", i),   out_rt,   tab[i].e_rt);
            chk($sformatf("vec%0d_dbg_dado", i), dbg_dado, tab[i].e_dbg);
        end

        // Fill regs 1..4, then reset asynchronously between clock edges.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            dirige(1'b1, 5'(i), 32'h01010101 * i, 5'd0, 5'd0, 5'd0);
        end
        @(negedge clock);
        dirige(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd1);
        #1;
        chk("pre_reset_rs3",  out_rs,   32'h03030303);
        chk("pre_reset_rt4",  out_rt,   32'h04040404);
        chk("pre_reset_dbg1", dbg_dado, 32'h01010101);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_rs3",  out_rs,   32'h0);
        chk("async_reset_rt4",  out_rt,   32'h0);
        chk("async_reset_dbg1", dbg_dado, 32'h0);

        escrever = 1'b1; rd_escrita = 5'd3; dado_escrita = 32'hABCD1234;
        #1;
        chk("write_in_reset_comb", out_rs, 32'h0);
        @(posedge clock);
        #1;
        chk("write_in_reset_post", out_rs, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        escrever = 1'b0;
        #1;
        chk("after_reset_rs3", out_rs, 32'h0);
        @(posedge clock);
        #1;
        chk("after_reset_rs3_edge", out_rs, 32'h0);

        // Post-reset write is visible right after the edge.
        @(negedge clock);
        dirige(1'b1, 5'd3, 32'h0BADF00D, 5'd3, 5'd0, 5'd3);
        @(posedge clock);
        #1;
        escrever = 1'b0;
        chk("post_reset_write_rs",  out_rs,   32'h0BADF00D);
        chk("post_reset_write_dbg", dbg_dado, 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
